// File: rtl/sfu_warp_sequencer_if.sv
// SFU op encoding shared by the sequencer and its neighbours, plus the
// instruction-in / warp-result-out bundle used as the sequencer's port.
package sfu_warp_pkg;
  typedef enum logic [2:0] {
    SFU_RCP = 3'd0,
    SFU_RSQ = 3'd1,
    SFU_LG2 = 3'd2,
    SFU_EX2 = 3'd3,
    SFU_SIN = 3'd4,
    SFU_COS = 3'd5
  } sfu_op_t;
endpackage

// Handshake rule for both directions: a transfer happens on a rising clk edge
// where valid && ready; the sender holds its payload stable until that edge.
interface sfu_warp_sequencer_if #(
  parameter int WARP_SIZE = 32,
  parameter int WID_BITS  = 5,
  parameter int REG_BITS  = 5
) ();
  logic                      in_valid;
  logic                      in_ready;
  sfu_warp_pkg::sfu_op_t     in_op;
  logic [WARP_SIZE-1:0]      in_mask;
  logic [WARP_SIZE*16-1:0]   in_operands;
  logic [WID_BITS-1:0]       in_warp_id;
  logic [REG_BITS-1:0]       in_dest;
  logic                      out_valid;
  logic                      out_ready;
  logic [WARP_SIZE*16-1:0]   out_results;
  logic [WARP_SIZE-1:0]      out_mask;
  logic [WID_BITS-1:0]       out_warp_id;
  logic [REG_BITS-1:0]       out_dest;

  modport master (
    output in_valid, in_op, in_mask, in_operands, in_warp_id, in_dest, out_ready,
    input  in_ready, out_valid, out_results, out_mask, out_warp_id, out_dest
  );

  modport slave (
    input  in_valid, in_op, in_mask, in_operands, in_warp_id, in_dest, out_ready,
    output in_ready, out_valid, out_results, out_mask, out_warp_id, out_dest
  );
endinterface

// File: rtl/sfu_warp_sequencer.sv
// Serialises one warp-wide SFU instruction over SFU_LANES combinational SFUs,
// one non-empty lane-group per cycle, and hands the assembled result to writeback.
module sfu_warp_sequencer
  import sfu_warp_pkg::*;
#(
  parameter int WARP_SIZE = 32,
  parameter int SFU_LANES = 8,
  parameter int WID_BITS  = 5,
  parameter int REG_BITS  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sfu_warp_sequencer_if.slave     io,
  output sfu_op_t                 sfu_op,
  output logic [SFU_LANES*16-1:0] sfu_operand,
  input  logic [SFU_LANES*16-1:0] sfu_result,
  output logic                    busy
);
  localparam int NUM_GRP  = WARP_SIZE / SFU_LANES;
  localparam int GRP_BITS = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  if (WARP_SIZE % SFU_LANES != 0) begin : g_param_check
    $error("WARP_SIZE must be a multiple of SFU_LANES");
  end

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state, state_d;
  logic [GRP_BITS-1:0]     ptr, ptr_d;
  sfu_op_t                 op_q;
  logic [WARP_SIZE-1:0]    mask_q;
  logic [WARP_SIZE*16-1:0] opnd_q;
  logic [WID_BITS-1:0]     wid_q;
  logic [REG_BITS-1:0]     dest_q;
  logic [WARP_SIZE*16-1:0] res_q, res_d;
  logic                    accept;
  logic [GRP_BITS:0]       first_hit, next_hit;
  logic [SFU_LANES-1:0]    cur_mask;
  logic [SFU_LANES*16-1:0] cur_opnd;

  // Lowest group at or above 'from' with any active lane; MSB flags a hit.
  function automatic logic [GRP_BITS:0] find_grp(input logic [WARP_SIZE-1:0] m,
                                                 input int from);
    logic [GRP_BITS:0] r;
    r = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      if (g >= from && |m[g*SFU_LANES +: SFU_LANES]) r = {1'b1, GRP_BITS'(g)};
    end
    return r;
  endfunction

  assign accept    = io.in_valid && io.in_ready;
  assign first_hit = find_grp(io.in_mask, 0);
  assign next_hit  = find_grp(mask_q, int'(ptr) + 1);
  assign cur_mask  = SFU_LANES'(mask_q >> (int'(ptr) * SFU_LANES));
  assign cur_opnd  = (SFU_LANES*16)'(opnd_q >> (int'(ptr) * SFU_LANES * 16));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        if (accept) begin
          ptr_d   = first_hit[GRP_BITS-1:0];
          state_d = first_hit[GRP_BITS] ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (next_hit[GRP_BITS]) ptr_d = next_hit[GRP_BITS-1:0];
        else                    state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Inactive lanes see a zero operand and never overwrite their cleared slot.
  always_comb begin
    sfu_operand = '0;
    res_d       = res_q;
    if (accept) res_d = '0;
    if (state == EXEC) begin
      for (int j = 0; j < SFU_LANES; j++) begin
        if (cur_mask[j]) begin
          sfu_operand[j*16 +: 16] = cur_opnd[j*16 +: 16];
          res_d[(int'(ptr) * SFU_LANES + j) * 16 +: 16] = sfu_result[j*16 +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= sfu_op_t'('0);
      mask_q <= '0;
      opnd_q <= '0;
      wid_q  <= '0;
      dest_q <= '0;
      res_q  <= '0;
    end else begin
      res_q <= res_d;
      if (accept) begin
        op_q   <= io.in_op;
        mask_q <= io.in_mask;
        opnd_q <= io.in_operands;
        wid_q  <= io.in_warp_id;
        dest_q <= io.in_dest;
      end
    end
  end

  assign io.in_ready    = (state == IDLE);
  assign io.out_valid   = (state == DONE);
  assign busy           = (state != IDLE);
  assign sfu_op         = op_q;
  assign io.out_results = res_q;
  assign io.out_mask    = mask_q;
  assign io.out_warp_id = wid_q;
  assign io.out_dest    = dest_q;
endmodule

// File: tb/tb_sfu_warp_sequencer.sv
// Bench for sfu_warp_sequencer: table-driven warps with a scoreboard, plus
// backpressure and asynchronous-reset sequences. SFU stub returns operand^FFFF.
module tb_sfu_warp_sequencer;
  import sfu_warp_pkg::*;

  localparam int WS = 32;
  localparam int SL = 8;
  localparam int NG = WS / SL;

  logic              clk;
  logic              rst_n;
  sfu_op_t           sfu_op;
  logic [SL*16-1:0]  sfu_operand;
  logic [SL*16-1:0]  sfu_result;
  logic              busy;

  sfu_warp_sequencer_if #(.WARP_SIZE(WS), .WID_BITS(5), .REG_BITS(5)) io ();

  sfu_warp_sequencer #(.WARP_SIZE(WS), .SFU_LANES(SL), .WID_BITS(5), .REG_BITS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (io),
    .sfu_op      (sfu_op),
    .sfu_operand (sfu_operand),
    .sfu_result  (sfu_result),
    .busy        (busy)
  );

  assign sfu_result = sfu_operand ^ {SL*16{1'b1}};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic [WS-1:0] mask;
    logic [4:0]    wid;
    logic [4:0]    dest;
  } meta_t;

  typedef struct {
    logic [WS-1:0] mask;
    int            pattern;
    sfu_op_t       op;
    logic [4:0]    wid;
    logic [4:0]    dest;
    int            hold;
    int            exp_lat;
  } vec_t;

  logic [WS*16-1:0] exp_q[$];
  meta_t            meta_q[$];
  int               n_cmp;
  int               n_fail;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [WS*16-1:0] make_ops(input int pattern);
    logic [WS*16-1:0] o;
    for (int i = 0; i < WS; i++) begin
      if (pattern == 0) o[i*16 +: 16] = 16'h0100 * i[15:0];
      else              o[i*16 +: 16] = 16'($urandom);
    end
    return o;
  endfunction

  function automatic logic [WS*16-1:0] model_res(input logic [WS-1:0] m, input logic [WS*16-1:0] ops);
    logic [WS*16-1:0] r;
    for (int i = 0; i < WS; i++) r[i*16 +: 16] = m[i] ? ~ops[i*16 +: 16] : 16'h0000;
    return r;
  endfunction

  // driver: present one instruction; caller guarantees in_ready at the next edge
  task automatic send(input logic [WS-1:0] m, input logic [WS*16-1:0] ops, input sfu_op_t op,
                      input logic [4:0] wid, input logic [4:0] dest);
    meta_t md;
    io.in_valid    = 1'b1;
    io.in_mask     = m;
    io.in_operands = ops;
    io.in_op       = op;
    io.in_warp_id  = wid;
    io.in_dest     = dest;
    md.mask = m; md.wid = wid; md.dest = dest;
    exp_q.push_back(model_res(m, ops));
    meta_q.push_back(md);
    @(posedge clk); #1;
    io.in_valid    = 1'b0;
    io.in_mask     = $urandom;
    io.in_operands = make_ops(1);
    io.in_warp_id  = 5'($urandom);
    io.in_dest     = 5'($urandom);
  endtask

  // called just after the accept edge: checks each issue cycle, latency and the result
  task automatic wait_result(input logic [WS-1:0] m, input logic [WS*16-1:0] ops, input sfu_op_t op,
                             input int exp_lat, output logic [WS*16-1:0] res_exp);
    int grps[$];
    int k;
    int want;
    logic [SL*16-1:0] eo;
    meta_t md;
    for (int g = 0; g < NG; g++) if (|m[g*SL +: SL]) grps.push_back(g);
    want = (exp_lat >= 0) ? exp_lat : grps.size();
    k = 0;
    while (io.out_valid !== 1'b1 && k < 20) begin
      eo = '0;
      if (k < grps.size()) begin
        for (int j = 0; j < SL; j++) begin
          if (m[grps[k]*SL + j]) eo[j*16 +: 16] = ops[(grps[k]*SL + j)*16 +: 16];
        end
      end
      check("sfu_issue", {sfu_op, sfu_operand}, {op, eo});
      k++;
      @(posedge clk); #1;
    end
    check("latency", k, want);
    res_exp = '0;
    if (exp_q.size() == 0 || meta_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard: got empty queue want pending entry");
      return;
    end
    res_exp = exp_q.pop_front();
    md      = meta_q.pop_front();
    check("out_results", io.out_results, res_exp);
    check("out_tags", {io.out_mask, io.out_warp_id, io.out_dest}, {md.mask, md.wid, md.dest});
    check("done_operand", sfu_operand, '0);
  endtask

  task automatic hold_check(input int cycles, input logic [WS*16-1:0] res_exp);
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (!(io.out_valid === 1'b1 && io.in_ready === 1'b0 && busy === 1'b1 &&
            io.out_results === res_exp)) ok = 1'b0;
      @(posedge clk); #1;
    end
    if (cycles > 0) check("hold_stable", ok, 1);
  endtask

  task automatic release_out();
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    check("after_handshake", {io.out_valid, io.in_ready, busy}, 3'b010);
  endtask

  vec_t             vecs[7];
  logic [WS*16-1:0] ops;
  logic [WS*16-1:0] ops_b;
  logic [WS*16-1:0] res_exp;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.in_op = SFU_RCP;
    io.in_mask = '0;
    io.in_operands = '0;
    io.in_warp_id = '0;
    io.in_dest = '0;
    io.out_ready = 1'b0;

    vecs[0] = '{mask: 32'hFFFFFFFF, pattern: 0, op: SFU_SIN, wid: 5'd3,  dest: 5'd7,  hold: 0, exp_lat: 4};
    vecs[1] = '{mask: 32'h0F000001, pattern: 1, op: SFU_COS, wid: 5'd5,  dest: 5'd9,  hold: 2, exp_lat: 2};
    vecs[2] = '{mask: 32'h00000000, pattern: 1, op: SFU_RCP, wid: 5'd31, dest: 5'd17, hold: 0, exp_lat: 0};
    vecs[3] = '{mask: 32'h80000000, pattern: 1, op: SFU_EX2, wid: 5'd12, dest: 5'd1,  hold: 1, exp_lat: 1};
    vecs[4] = '{mask: 32'h00FF00FF, pattern: 0, op: SFU_LG2, wid: 5'd20, dest: 5'd30, hold: 0, exp_lat: 2};
    vecs[5] = '{mask: $urandom,     pattern: 1, op: SFU_RSQ, wid: 5'd8,  dest: 5'd4,  hold: 3, exp_lat: -1};
    vecs[6] = '{mask: $urandom,     pattern: 1, op: SFU_SIN, wid: 5'd27, dest: 5'd22, hold: 0, exp_lat: -1};

    #1;
    check("reset_ctrl", {io.out_valid, busy, io.in_ready}, 3'b001);
    check("reset_data", {io.out_results, sfu_operand}, '0);
    check("reset_tags", {io.out_mask, io.out_warp_id, io.out_dest}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      ops = make_ops(vecs[v].pattern);
      send(vecs[v].mask, ops, vecs[v].op, vecs[v].wid, vecs[v].dest);
      wait_result(vecs[v].mask, ops, vecs[v].op, vecs[v].exp_lat, res_exp);
      hold_check(vecs[v].hold, res_exp);
      release_out();
    end

    // backpressure with a second instruction waiting upstream
    ops = make_ops(1);
    send(32'h00F0F00F, ops, SFU_COS, 5'd2, 5'd11);
    wait_result(32'h00F0F00F, ops, SFU_COS, 3, res_exp);
    ops_b = make_ops(0);
    io.in_valid = 1'b1;
    io.in_mask = 32'hFFFF0000;
    io.in_operands = ops_b;
    io.in_op = SFU_EX2;
    io.in_warp_id = 5'd9;
    io.in_dest = 5'd6;
    hold_check(10, res_exp);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    check("pending_not_taken", {io.out_valid, io.in_ready, busy}, 3'b010);
    exp_q.push_back(model_res(32'hFFFF0000, ops_b));
    meta_q.push_back('{mask: 32'hFFFF0000, wid: 5'd9, dest: 5'd6});
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    check("pending_taken", {io.in_ready, busy}, 2'b01);
    wait_result(32'hFFFF0000, ops_b, SFU_EX2, 2, res_exp);
    release_out();

    // asynchronous reset in the second issue cycle
    ops = make_ops(1);
    send(32'hFFFFFFFF, ops, SFU_SIN, 5'd14, 5'd15);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {io.out_valid, busy, io.in_ready}, 3'b001);
    check("async_rst_data", {io.out_results, sfu_operand}, '0);
    check("async_rst_tags", {io.out_mask, io.out_warp_id, io.out_dest}, '0);
    void'(exp_q.pop_back());
    void'(meta_q.pop_back());
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ops = make_ops(1);
    send(32'h12345678, ops, SFU_RCP, 5'd1, 5'd2);
    wait_result(32'h12345678, ops, SFU_RCP, 4, res_exp);
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
